mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 single-bit mux datapath (`mux_4_2_to_1`) between four requesters. It accepts per-requester request lines, grants one requester at a time with a bounded hold time, and drives the mux selects `s1`/`s2` from a registered grant. It sits between the four 1-bit sources `a`..`d` and the downstream consumer of `y`. Grant state is registered; data passes through combinationally.

## Interface
- `MAX_HOLD`, 4: maximum consecutive cycles one owner keeps the grant; legal range 1..2^`CNT_W`.
- `CNT_W`, 3: width of the hold counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  4  request lines; bit i requests access for source i (0=`a`, 1=`b`, 2=`c`, 3=`d`).
- `a`, `b`, `c`, `d`  in  1 each  source data bits.
- `gnt`  out  4  one-hot grant, registered; all zero when idle.
- `s1`  out  1  mux select MSB, registered.
- `s2`  out  1  mux select LSB, registered.
- `y`  out  1  selected data from the internal mux.
- `valid`  out  1  high when `gnt` is nonzero; qualifies `y`.

## Operation
- Select encoding: {`s1`,`s2`} equals the owner index. 00 selects `a`, 01 `b`, 10 `c`, 11 `d`.
- FSM states:
  - IDLE: `gnt`=0. If `req`≠0, go to GRANT and grant the first requesting index after `last`, searching cyclically.
  - GRANT: owner = index held in `gnt`; `hold_cnt` increments once per cycle.
- Release from GRANT occurs when `req[owner]`=0 or `hold_cnt`=`MAX_HOLD`-1. Both conditions in the same cycle cause a single release.
- On release:
  - `last` is set to owner.
  - If any `req` bit is set (excluding `req[owner]` when it has dropped), grant the next requester cyclically after owner on the same edge. There is no idle bubble.
  - If no request is pending, go to IDLE.
- Hold expiry with only the owner still requesting re-grants the same owner and clears `hold_cnt`, with no gap.
- A new grant always loads `hold_cnt`=0.
- `req` bits for non-owners are ignored while a grant is held; there is no preemption.
- `s1`/`s2` hold their last value in IDLE. `y` still reflects that source, but `valid`=0.
- Reset values: state IDLE, `gnt`=0000, `s1`=0, `s2`=0, `valid`=0, `hold_cnt`=0, `last`=3 (requester 0 has first priority).

## Timing
- Request to grant: 1 cycle. `req` sampled at edge N produces `gnt`/`s1`/`s2` valid after edge N.
- Owner drop to handover: `req[owner]` low at edge N changes `gnt` after edge N.
- Grant duration: at most `MAX_HOLD` cycles per tenure.
- `y` follows the selected source combinationally within the same cycle; there is no data latency.
- `rst` high at any edge, including mid-grant, forces all reset values after that edge. `req` is ignored while `rst` is high.

## Structure
- Shared include file `mux4_defs.vh` holds:
  - state encodings `ST_IDLE`/`ST_GRANT`;
  - requester index localparams `SRC_A`..`SRC_D`;
  - the select encoding.
- One sub-module: `mux_4_2_to_1`, instantiated as the datapath, with selects driven from the registered `s1`/`s2`.
- Next-owner search is a combinational rotate-priority function inside the top module. It does not need a separate module.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0000, {`s1`,`s2`}=00, `valid`=0. Release `rst` → `gnt`=0001 after the next edge.
- Single requester: `req`=0100, `c`=1, held for 10 cycles → after the first edge `gnt`=0100, {`s1`,`s2`}=10, `y`=1, `valid`=1. `gnt` stays 0100 continuously, including re-grants at cycles 4 and 8.
- Full contention: `req`=1111 held → `gnt` sequence 0001, 0010, 0100, 1000, 0001, each lasting exactly 4 cycles, with `valid` never dropping.
- Early release: `req`=0101 with owner 0; drop `req[0]` after 2 cycles → `gnt`=0100 on the edge where the drop is sampled. Total tenure of owner 0 is 2 cycles.
- Reset mid-grant: owner 2 granted, assert `rst` for 1 cycle with `req`=1010 → `gnt`=0000. After `rst` is released, `gnt`=0010 (the pointer has been reset).
- Pass-through: owner 3 granted, toggle `d` every cycle → `y` equals `d` in the same cycle, and `a`..`c` toggling has no effect on `y`.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the 4:1 bit mux.
// The select encoding is {s1,s2} == requester index: 00=a, 01=b, 10=c, 11=d.
package mux4_rr_arbiter_pkg;

    localparam int N_SRC = 4;

    typedef logic [1:0]       src_idx_t;
    typedef logic [N_SRC-1:0] src_vec_t;

    localparam src_idx_t SRC_A = 2'd0;
    localparam src_idx_t SRC_B = 2'd1;
    localparam src_idx_t SRC_C = 2'd2;
    localparam src_idx_t SRC_D = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Result of a rotate-priority search: whether anyone was found, and who.
    typedef struct packed {
        logic     found;
        src_idx_t idx;
    } pick_t;

    function automatic src_vec_t idx_to_onehot(src_idx_t idx);
        return src_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of request, source data, grant and mux-select signals between the
// four sources/consumer (master side) and the arbiter (slave side).
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    src_vec_t req;
    logic     a;
    logic     b;
    logic     c;
    logic     d;
    src_vec_t gnt;
    logic     s1;
    logic     s2;
    logic     y;
    logic     valid;

    modport master (
        output req, a, b, c, d,
        input  gnt, s1, s2, y, valid
    );

    modport slave (
        input  req, a, b, c, d,
        output gnt, s1, s2, y, valid
    );

endinterface

// File: rtl/mux4_rr_arbiter_mux.sv
// Single-bit 4:1 mux datapath; {s1_i,s2_i} is the binary index of the selected input.
module mux_4_2_to_1 (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic d_i,
    input  logic s1_i,
    input  logic s2_i,
    output logic y_o
);

    always_comb begin
        unique case ({s1_i, s2_i})
            2'b00:   y_o = a_i;
            2'b01:   y_o = b_i;
            2'b10:   y_o = c_i;
            default: y_o = d_i;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux between four requesters, with a
// bounded hold time per tenure and registered grant/select outputs.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    mux4_rr_arbiter_if.slave   arb_if
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    src_vec_t         gnt_q,   gnt_d;
    src_idx_t         sel_q,   sel_d;
    src_idx_t         last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic  release_grant;
    pick_t pick;

    // First requester strictly after `after`, wrapping; `after` itself is tried last.
    function automatic pick_t rr_pick(src_vec_t r, src_idx_t after);
        pick_t    p;
        src_idx_t cand;
        p.found = 1'b0;
        p.idx   = after;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = after + src_idx_t'(k);
            if (!p.found && r[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    // In GRANT the search pivots on the current owner; in IDLE on the last owner.
    // A dropped owner request is already zero in req, so it is excluded naturally.
    assign pick          = rr_pick(arb_if.req, (state_q == ST_GRANT) ? sel_q : last_q);
    assign release_grant = !arb_if.req[sel_q] || (cnt_q == HOLD_LAST);

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    state_d = ST_GRANT;
                    gnt_d   = idx_to_onehot(pick.idx);
                    sel_d   = pick.idx;
                    cnt_d   = '0;
                end
            end

            ST_GRANT: begin
                if (release_grant) begin
                    last_d = sel_q;
                    if (pick.found) begin
                        gnt_d = idx_to_onehot(pick.idx);
                        sel_d = pick.idx;
                        cnt_d = '0;
                    end else begin
                        // Selects keep the old owner so y stays stable while idle.
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= SRC_A;
            last_q  <= SRC_D;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign arb_if.gnt   = gnt_q;
    assign arb_if.s1    = sel_q[1];
    assign arb_if.s2    = sel_q[0];
    assign arb_if.valid = |gnt_q;

    mux_4_2_to_1 u_mux (
        .a_i  (arb_if.a),
        .b_i  (arb_if.b),
        .c_i  (arb_if.c),
        .d_i  (arb_if.d),
        .s1_i (sel_q[1]),
        .s2_i (sel_q[0]),
        .y_o  (arb_if.y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter: reset, contention rotation,
// single-requester re-grant, early release, mid-grant reset, idle and pass-through.
module tb_mux4_rr_arbiter;
    import mux4_rr_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] sel, input logic v);
        check({tag, ".gnt"},   32'(bus.gnt), 32'(g));
        check({tag, ".sel"},   32'({bus.s1, bus.s2}), 32'(sel));
        check({tag, ".valid"}, 32'(bus.valid), 32'(v));
    endtask

    logic [3:0] rot_gnt [5];
    logic [1:0] rot_sel [5];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset held two edges with all requesting: nothing granted.
        rst     = 1'b1;
        bus.req = 4'b1111;
        bus.a   = 1'b0;
        bus.b   = 1'b1;
        bus.c   = 1'b1;
        bus.d   = 1'b1;
        tick();
        tick();
        check_grant("reset", 4'b0000, 2'd0, 1'b0);
        check("reset.y_is_a", 32'(bus.y), 32'd0);

        // Full contention: each owner keeps exactly 4 cycles, requester 0 first.
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                check_grant($sformatf("rot%0d_c%0d", i, k), rot_gnt[i], rot_sel[i], 1'b1);
                tick();
            end
        end
        // Owner 0 expired with everyone still requesting: handed to 1.
        check_grant("rot_wrap", 4'b0010, 2'd1, 1'b1);

        // Single requester c: owner 1 drops, c granted and re-granted with no gap.
        bus.req = 4'b0100;
        bus.a   = 1'b0;
        bus.b   = 1'b0;
        bus.c   = 1'b1;
        bus.d   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_grant($sformatf("single_c%0d", k), 4'b0100, 2'd2, 1'b1);
            check($sformatf("single_c%0d.y", k), 32'(bus.y), 32'd1);
        end

        // Early release: owner 0 with 2 also requesting, 0 drops after 2 cycles.
        bus.req = 4'b0001;
        tick();
        check_grant("early.owner0", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b0101;
        tick();
        check_grant("early.hold", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b0100;
        tick();
        check_grant("early.handover", 4'b0100, 2'd2, 1'b1);

        // Reset mid-grant of owner 2: pointer returns to favour requester 0 first.
        bus.req = 4'b1010;
        rst     = 1'b1;
        tick();
        check_grant("midrst", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        check_grant("midrst.after", 4'b0010, 2'd1, 1'b1);

        // Pass-through: owner 3, y tracks d only, in the same cycle.
        bus.req = 4'b1000;
        tick();
        check_grant("pass.owner3", 4'b1000, 2'd3, 1'b1);
        for (int k = 0; k < 6; k++) begin
            bus.d = k[0];
            bus.a = ~k[0];
            bus.b = ~k[0];
            bus.c = ~k[0];
            #1;
            check($sformatf("pass%0d.y", k), 32'(bus.y), 32'(k[0]));
            bus.a = k[0];
            bus.b = k[0];
            bus.c = k[0];
            #1;
            check($sformatf("pass%0d.y_abc", k), 32'(bus.y), 32'(k[0]));
            tick();
            check_grant($sformatf("pass%0d", k), 4'b1000, 2'd3, 1'b1);
        end

        // Idle: selects hold at 11, y still shows d, valid low.
        bus.req = 4'b0000;
        bus.d   = 1'b1;
        bus.a   = 1'b0;
        tick();
        check_grant("idle", 4'b0000, 2'd3, 1'b0);
        check("idle.y", 32'(bus.y), 32'd1);
        tick();
        check_grant("idle.stay", 4'b0000, 2'd3, 1'b0);

        // From idle with last=3, requesters 1 and 3: search wraps to 1 first.
        bus.req = 4'b1010;
        tick();
        check_grant("idle.regrant", 4'b0010, 2'd1, 1'b1);
        check("idle.regrant.y", 32'(bus.y), 32'(bus.b));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
